// File: rtl/cp0_access_unit_pkg.sv
// Shared types and constants for the CP0 access path: request structs,
// CP0 register numbers and the per-register write mask.
package cp0_access_unit_pkg;

    typedef logic [31:0] word_t;

    // Read request sent to cp0; raddr/rsel come straight from EX.
    typedef struct packed {
        logic [4:0] raddr;
        logic [2:0] rsel;
    } cp0_rreq_t;

    // Write request sent to cp0; we is a single-cycle strobe per MTC0.
    typedef struct packed {
        logic       we;
        logic [4:0] waddr;
        logic [2:0] wsel;
        word_t      wdata;
    } cp0_wreq_t;

    // In-flight MTC0 slot used for MEM and WB.
    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic [2:0] sel;
        word_t      data;
    } slot_t;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // Cause: only IV (bit 23) and the software interrupt bits IP1:IP0 are writable.
    localparam word_t CAUSE_WMASK = 32'h0080_0300;

    // Bits an MTC0 actually changes; zero means the register is not writable
    // from software and must never be forwarded.
    function automatic word_t cp0_wmask(input logic [4:0] addr, input logic [2:0] sel);
        word_t m;
        m = '0;
        if (sel == 3'd0) begin
            case (addr)
                CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_EPC: m = '1;
                CP0_CAUSE:                                   m = CAUSE_WMASK;
                default:                                     m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/cp0_access_unit_fwd_merge.sv
// Combinational merge of an in-flight MTC0 value over an older register
// value, restricted to the bits that MTC0 can really change.
module cp0_fwd_merge
    import cp0_access_unit_pkg::*;
(
    input  logic [4:0] addr,
    input  logic [2:0] sel,
    input  word_t      old_data,
    input  word_t      new_data,
    output word_t      merged,
    output logic       writable
);

    word_t mask;

    // Apply the register's write mask: masked bits from new_data, rest from old_data.
    always_comb begin
        mask     = cp0_wmask(addr, sel);
        writable = |mask;
        merged   = (old_data & ~mask) | (new_data & mask);
    end

endmodule

// File: rtl/cp0_access_unit.sv
// Pipeline-side CP0 initiator: carries MTC0 through MEM/WB slots, issues the
// WB write, forwards in-flight MTC0 data to MFC0 in EX and registers the
// interrupt-pending flag from the effective Status/Cause.
//
// Slot valid semantics: a slot with valid=1 holds exactly one MTC0 that has
// not yet been written to cp0. WB.valid is the write strobe itself, so a slot
// is only ever in WB for one cycle; stall replaces WB with a bubble instead of
// holding it, which is what guarantees a single write per MTC0.
module cp0_access_unit
    import cp0_access_unit_pkg::*;
#(
    parameter int FWD_EN  = 1,
    parameter int EXL_BIT = 1,
    parameter int IE_BIT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mfc0_valid,
    input  logic        ex_mtc0_valid,
    input  logic [4:0]  ex_cp0_addr,
    input  logic [2:0]  ex_cp0_sel,
    input  logic [31:0] ex_mtc0_wdata,
    input  logic        stall,
    input  logic        flush,
    output cp0_rreq_t   cp0_rreq,
    input  logic [31:0] cp0_rdata,
    output logic [31:0] ex_rdata,
    output cp0_wreq_t   cp0_wreq,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    output logic        int_pending
);

    localparam bit FWD_ON = (FWD_EN != 0);

    slot_t mem_q, mem_d;
    slot_t wb_q, wb_d;

    word_t mem_merged, wb_merged, ov_merged, ov_old;
    logic  mem_wr, wb_wr, ov_wr;
    logic  mem_hit, wb_hit;
    word_t eff_status, eff_cause;
    logic  int_pending_d;

    // Slot advance: flush kills MEM (WB still takes old MEM), stall holds MEM and bubbles WB.
    always_comb begin
        mem_d = mem_q;
        wb_d  = mem_q;
        if (flush) begin
            mem_d = '0;
        end else if (stall) begin
            wb_d = '0;
        end else if (ex_mtc0_valid) begin
            mem_d.valid = 1'b1;
            mem_d.addr  = ex_cp0_addr;
            mem_d.sel   = ex_cp0_sel;
            mem_d.data  = ex_mtc0_wdata;
        end else begin
            mem_d = '0;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Read request is a direct view of the EX fields, independent of valid.
    always_comb begin
        cp0_rreq.raddr = ex_cp0_addr;
        cp0_rreq.rsel  = ex_cp0_sel;
    end

    // Write request is the WB slot itself.
    always_comb begin
        cp0_wreq.we    = wb_q.valid;
        cp0_wreq.waddr = wb_q.addr;
        cp0_wreq.wsel  = wb_q.sel;
        cp0_wreq.wdata = wb_q.data;
    end

    cp0_fwd_merge u_mem_fwd (
        .addr     (mem_q.addr),
        .sel      (mem_q.sel),
        .old_data (cp0_rdata),
        .new_data (mem_q.data),
        .merged   (mem_merged),
        .writable (mem_wr)
    );

    cp0_fwd_merge u_wb_fwd (
        .addr     (wb_q.addr),
        .sel      (wb_q.sel),
        .old_data (cp0_rdata),
        .new_data (wb_q.data),
        .merged   (wb_merged),
        .writable (wb_wr)
    );

    // Forwarding hit detection; only writable registers can produce a hit.
    always_comb begin
        mem_hit = FWD_ON && mem_q.valid && mem_wr &&
                  (mem_q.addr == ex_cp0_addr) && (mem_q.sel == ex_cp0_sel);
        wb_hit  = FWD_ON && wb_q.valid && wb_wr &&
                  (wb_q.addr == ex_cp0_addr) && (wb_q.sel == ex_cp0_sel);
    end

    // MFC0 result: the younger MEM slot wins over WB, otherwise cp0 data.
    always_comb begin
        ex_rdata = cp0_rdata;
        if (ex_mfc0_valid) begin
            if (mem_hit) begin
                ex_rdata = mem_merged;
            end else if (wb_hit) begin
                ex_rdata = wb_merged;
            end
        end
    end

    // Select which CP0 value the WB write would overlay.
    always_comb begin
        ov_old = (wb_q.addr == CP0_CAUSE) ? cause_i : status_i;
    end

    cp0_fwd_merge u_sc_overlay (
        .addr     (wb_q.addr),
        .sel      (wb_q.sel),
        .old_data (ov_old),
        .new_data (wb_q.data),
        .merged   (ov_merged),
        .writable (ov_wr)
    );

    // Effective Status/Cause as they will be once the WB write lands.
    always_comb begin
        eff_status = status_i;
        eff_cause  = cause_i;
        if (wb_q.valid && ov_wr && (wb_q.addr == CP0_STATUS)) begin
            eff_status = ov_merged;
        end
        if (wb_q.valid && ov_wr && (wb_q.addr == CP0_CAUSE)) begin
            eff_cause = ov_merged;
        end
        int_pending_d = eff_status[IE_BIT] & ~eff_status[EXL_BIT] &
                        (|(eff_cause[15:8] & eff_status[15:8]));
    end

    // Interrupt flag registered every cycle, independent of stall/flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_pending <= 1'b0;
        end else begin
            int_pending <= int_pending_d;
        end
    end

endmodule

// File: tb/tb_cp0_access_unit.sv
// Directed bench for cp0_access_unit: forwarding table plus hand-written
// sequences for write timing, stall, flush and the interrupt flag.
module tb_cp0_access_unit;
    import cp0_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mfc0_valid, ex_mtc0_valid;
    logic [4:0]  ex_cp0_addr;
    logic [2:0]  ex_cp0_sel;
    logic [31:0] ex_mtc0_wdata;
    logic        stall, flush;
    cp0_rreq_t   cp0_rreq;
    logic [31:0] cp0_rdata;
    logic [31:0] ex_rdata;
    cp0_wreq_t   cp0_wreq;
    logic [31:0] status_i, cause_i;
    logic        int_pending;

    cp0_access_unit #(.FWD_EN(1), .EXL_BIT(1), .IE_BIT(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_mfc0_valid (ex_mfc0_valid),
        .ex_mtc0_valid (ex_mtc0_valid),
        .ex_cp0_addr   (ex_cp0_addr),
        .ex_cp0_sel    (ex_cp0_sel),
        .ex_mtc0_wdata (ex_mtc0_wdata),
        .stall         (stall),
        .flush         (flush),
        .cp0_rreq      (cp0_rreq),
        .cp0_rdata     (cp0_rdata),
        .ex_rdata      (ex_rdata),
        .cp0_wreq      (cp0_wreq),
        .status_i      (status_i),
        .cause_i       (cause_i),
        .int_pending   (int_pending)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected writes: {cycle[15:0], addr, sel, data}
    logic [55:0] exp_q[$];

    typedef struct packed {
        logic [4:0]  waddr;
        logic [2:0]  wsel;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [2:0]  rsel;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard for the write port, evaluated mid-cycle.
    task automatic check_write();
        logic [55:0] act;
        logic [55:0] front;
        act = {cyc[15:0], cp0_wreq.waddr, cp0_wreq.wsel, cp0_wreq.wdata};
        if (cp0_wreq.we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h expected none (cycle %0d)", act, cyc);
            end else begin
                front = exp_q.pop_front();
                if (front !== act) begin
                    errors++;
                    $display("FAIL write: got %h expected %h (cycle %0d)", act, front, cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0][55:40] == cyc[15:0]) begin
            checks++;
            errors++;
            $display("FAIL missing_write: got none expected %h (cycle %0d)", exp_q[0], cyc);
            void'(exp_q.pop_front());
        end
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        check_write();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_idle();
        ex_mfc0_valid = 1'b0;
        ex_mtc0_valid = 1'b0;
        ex_cp0_addr   = 5'd0;
        ex_cp0_sel    = 3'd0;
        ex_mtc0_wdata = 32'h0;
        stall         = 1'b0;
        flush         = 1'b0;
        cp0_rdata     = 32'h0;
    endtask

    // lat < 0: no write expected from this MTC0.
    task automatic drive_mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d, input int lat);
        int wc;
        ex_mtc0_valid = 1'b1;
        ex_cp0_addr   = a;
        ex_cp0_sel    = s;
        ex_mtc0_wdata = d;
        if (lat >= 0) begin
            wc = cyc + lat;
            exp_q.push_back({wc[15:0], a, s, d});
        end
    endtask

    task automatic drive_mfc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] rd);
        ex_mfc0_valid = 1'b1;
        ex_cp0_addr   = a;
        ex_cp0_sel    = s;
        cp0_rdata     = rd;
    endtask

    initial begin
        vecs[0] = '{5'd12, 3'd0, 32'h0000_FF01, 5'd12, 3'd0, 32'h1111_0000, 32'h0000_FF01};
        vecs[1] = '{5'd13, 3'd0, 32'hFFFF_FFFF, 5'd13, 3'd0, 32'h0000_0400, 32'h0080_0700};
        vecs[2] = '{5'd8,  3'd0, 32'hFFFF_FFFF, 5'd8,  3'd0, 32'h0000_0400, 32'h0000_0400};
        vecs[3] = '{5'd14, 3'd1, 32'hDEAD_BEEF, 5'd14, 3'd1, 32'h0000_1234, 32'h0000_1234};
        vecs[4] = '{5'd11, 3'd0, 32'hA5A5_5A5A, 5'd12, 3'd0, 32'h0000_0042, 32'h0000_0042};
        vecs[5] = '{5'd9,  3'd0, 32'h0000_0100, 5'd9,  3'd0, 32'h0000_0102, 32'h0000_0100};
        vecs[6] = '{5'd13, 3'd0, 32'h0000_0000, 5'd13, 3'd0, 32'hFFFF_FFFF, 32'hFF7F_FCFF};

        // Reset with an interrupt condition on the inputs: flag must stay low.
        rst = 1'b0;
        drive_idle();
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0400;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check32("reset_we", {31'h0, cp0_wreq.we}, 32'h0);
            check32("reset_int", {31'h0, int_pending}, 32'h0);
            tick();
        end
        rst = 1'b1;
        tick();
        check32("int_after_reset", {31'h0, int_pending}, 32'h1);
        status_i = 32'h0;
        cause_i  = 32'h0;
        tick();
        check32("int_cleared", {31'h0, int_pending}, 32'h0);
        check32("idle_we", {31'h0, cp0_wreq.we}, 32'h0);
        tick();

        // MTC0 $14 write timing: strobe only in the second cycle after EX.
        drive_mtc0(5'd14, 3'd0, 32'h8000_1234, 2);
        #1;
        check32("w14_c0_we", {31'h0, cp0_wreq.we}, 32'h0);
        tick();
        drive_idle();
        #1;
        check32("w14_c1_we", {31'h0, cp0_wreq.we}, 32'h0);
        tick();
        #1;
        check32("w14_c2_we", {31'h0, cp0_wreq.we}, 32'h1);
        check32("w14_c2_addr", {27'h0, cp0_wreq.waddr}, 32'd14);
        check32("w14_c2_data", cp0_wreq.wdata, 32'h8000_1234);
        tick();
        #1;
        check32("w14_c3_we", {31'h0, cp0_wreq.we}, 32'h0);
        tick();

        // Forwarding table: MTC0 then MFC0 sees it from MEM, then from WB.
        foreach (vecs[i]) begin
            drive_idle();
            drive_mtc0(vecs[i].waddr, vecs[i].wsel, vecs[i].wdata, 2);
            tick();
            drive_idle();
            drive_mfc0(vecs[i].raddr, vecs[i].rsel, vecs[i].rdata);
            #1;
            check32($sformatf("v%0d_rreq", i), {24'h0, cp0_rreq.raddr, cp0_rreq.rsel},
                    {24'h0, vecs[i].raddr, vecs[i].rsel});
            check32($sformatf("v%0d_mem_fwd", i), ex_rdata, vecs[i].exp);
            tick();
            drive_idle();
            drive_mfc0(vecs[i].raddr, vecs[i].rsel, vecs[i].rdata);
            #1;
            check32($sformatf("v%0d_wb_fwd", i), ex_rdata, vecs[i].exp);
            tick();
        end

        // MEM beats WB; no forward when MFC0 is not valid.
        drive_idle();
        drive_mtc0(5'd14, 3'd0, 32'h0000_0001, 2);
        tick();
        drive_idle();
        drive_mtc0(5'd14, 3'd0, 32'h0000_0002, 2);
        tick();
        drive_idle();
        drive_mfc0(5'd14, 3'd0, 32'h0000_0000);
        #1;
        check32("mem_over_wb", ex_rdata, 32'h0000_0002);
        ex_mfc0_valid = 1'b0;
        #1;
        check32("no_mfc0_passthru", ex_rdata, 32'h0000_0000);
        tick();
        drive_idle();
        tick();

        // Stall: MTC0 $11 held in MEM for 3 cycles, single write after release.
        drive_mtc0(5'd11, 3'd0, 32'h0000_0005, 5);
        tick();
        drive_idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check32("stall_we", {31'h0, cp0_wreq.we}, 32'h0);
            tick();
        end
        drive_idle();
        tick();
        #1;
        check32("stall_release_we", {31'h0, cp0_wreq.we}, 32'h1);
        tick();
        tick();

        // Flush discards the MTC0 in EX.
        drive_mtc0(5'd14, 3'd0, 32'h0000_0077, -1);
        flush = 1'b1;
        tick();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            check32("flush_ex_we", {31'h0, cp0_wreq.we}, 32'h0);
            tick();
        end

        // Flush with stall: MTC0 already in MEM still commits, EX one does not.
        drive_mtc0(5'd14, 3'd0, 32'h0000_0055, 2);
        tick();
        drive_idle();
        drive_mtc0(5'd11, 3'd0, 32'h0000_0099, -1);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        drive_idle();
        #1;
        check32("flush_mem_commit", cp0_wreq.wdata, 32'h0000_0055);
        tick();
        tick();
        tick();

        // Interrupt: one-cycle latency, then masked by EXL from a WB Status write.
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0400;
        #1;
        check32("int_latency_low", {31'h0, int_pending}, 32'h0);
        tick();
        check32("int_set", {31'h0, int_pending}, 32'h1);
        drive_mtc0(5'd12, 3'd0, 32'h0000_0403, 2);
        tick();
        drive_idle();
        tick();
        check32("int_wb_cycle", {31'h0, int_pending}, 32'h1);
        tick();
        check32("int_exl_masked", {31'h0, int_pending}, 32'h0);
        tick();
        check32("int_back", {31'h0, int_pending}, 32'h1);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: got %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
